// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and timeout defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Width of the mem_valid wait counter; TIMEOUT must fit in it.
    localparam int WAIT_W = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: picks the requester not granted last when both ask.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
// Ports: req[1:0] request per port, last_grant index granted previously,
//        grant_idx selected port, grant_vld high when any port requests.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_idx,
    output logic       grant_vld
);

    always_comb begin
        grant_vld = |req;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            // Single requester (or none): port 1 only when it alone asks.
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto one memory port: grant, strobe, wait for mem_valid, respond.
// Latency: request in t, strobe in t+1, done earliest in t+2; one idle cycle between grants.
// Backpressure: requests are held by the requester until done/error; memory stalls via mem_valid with timeout.
// Ports: rN_* requester side (read/write/address/write_value in, read_value/done/error out),
//        mem_* memory side (strobes, address, write data out; read data, valid in),
//        busy transaction in flight, grant_id port owning the memory.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [31:0] r0_address,
    input  logic [31:0] r0_write_value,
    output logic [31:0] r0_read_value,
    output logic        r0_done,
    output logic        r0_error,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [31:0] r1_address,
    input  logic [31:0] r1_write_value,
    output logic [31:0] r1_read_value,
    output logic        r1_done,
    output logic        r1_error,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_value,
    input  logic [31:0] mem_read_value,
    input  logic        mem_valid,
    output logic        busy,
    output logic        grant_id
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    state_t            state;
    logic              last_grant;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              gnt_idx;
    logic              gnt_vld;

    assign wait_nxt = wait_cnt + WAIT_W'(1);

    rr_arbiter2 u_rr (
        .req        ({r1_read | r1_write, r0_read | r0_write}),
        .last_grant (last_grant),
        .grant_idx  (gnt_idx),
        .grant_vld  (gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            last_grant       <= 1'b0;
            wait_cnt         <= '0;
            grant_id         <= 1'b0;
            busy             <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_value  <= '0;
            r0_read_value    <= '0;
            r1_read_value    <= '0;
            r0_done          <= 1'b0;
            r1_done          <= 1'b0;
            r0_error         <= 1'b0;
            r1_error         <= 1'b0;
        end else begin
            // Completion and error are single-cycle pulses.
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_error <= 1'b0;
            r1_error <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        grant_id         <= gnt_idx;
                        last_grant       <= gnt_idx;
                        mem_address      <= gnt_idx ? r1_address : r0_address;
                        mem_write_value  <= gnt_idx ? r1_write_value : r0_write_value;
                        // Write takes priority when both read and write are asserted.
                        mem_write_enable <= gnt_idx ? r1_write : r0_write;
                        mem_read_enable  <= gnt_idx ? ~r1_write : ~r0_write;
                        wait_cnt         <= '0;
                        busy             <= 1'b1;
                        state            <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (mem_valid) begin
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        if (mem_read_enable) begin
                            if (grant_id) r1_read_value <= mem_read_value;
                            else          r0_read_value <= mem_read_value;
                        end
                        r0_done <= ~grant_id;
                        r1_done <= grant_id;
                        state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_nxt;
                        // Give up once TIMEOUT wait cycles have passed without mem_valid.
                        if (wait_nxt == TIMEOUT_CNT) begin
                            mem_read_enable  <= 1'b0;
                            mem_write_enable <= 1'b0;
                            r0_error         <= ~grant_id;
                            r1_error         <= grant_id;
                            busy             <= 1'b0;
                            state            <= ST_IDLE;
                        end
                    end
                end

                ST_RESP: begin
                    // No grant here: guarantees an idle cycle between transactions.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Latency: checks the t / t+1 / t+2 request-strobe-done timing and the timeout distance.
// Backpressure: memory stalls modelled by withholding mem_valid.
module tb_mem_arbiter;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_read, r0_write, r1_read, r1_write;
    logic [31:0] r0_address, r0_write_value, r1_address, r1_write_value;
    logic [31:0] r0_read_value, r1_read_value;
    logic        r0_done, r0_error, r1_done, r1_error;
    logic        mem_read_enable, mem_write_enable;
    logic [31:0] mem_address, mem_write_value, mem_read_value;
    logic        mem_valid;
    logic        busy, grant_id;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .r0_read          (r0_read),
        .r0_write         (r0_write),
        .r0_address       (r0_address),
        .r0_write_value   (r0_write_value),
        .r0_read_value    (r0_read_value),
        .r0_done          (r0_done),
        .r0_error         (r0_error),
        .r1_read          (r1_read),
        .r1_write         (r1_write),
        .r1_address       (r1_address),
        .r1_write_value   (r1_write_value),
        .r1_read_value    (r1_read_value),
        .r1_done          (r1_done),
        .r1_error         (r1_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_value  (mem_write_value),
        .mem_read_value   (mem_read_value),
        .mem_valid        (mem_valid),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctl_bits();
        return {r0_done, r1_done, r0_error, r1_error,
                mem_read_enable, mem_write_enable, busy, grant_id};
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
        r0_address = 0; r0_write_value = 0; r1_address = 0; r1_write_value = 0;
        mem_read_value = 0; mem_valid = 0;
        repeat (3) tick();
        checks++;
        if (ctl_bits() !== 8'h00) begin
            errors++; $display("FAIL reset_ctl got %b want 00000000", ctl_bits());
        end
        checks++;
        if ({mem_address, mem_write_value, r0_read_value, r1_read_value} !== 128'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want zeros",
                               mem_address, mem_write_value, r0_read_value, r1_read_value);
        end
    endtask

    // Both ports held from reset: expected grants 1,0,1,0.
    task automatic test_round_robin;
        logic exp;
        reset_n = 1'b1;
        r0_read = 1; r0_address = 32'h10;
        r1_read = 1; r1_address = 32'h20;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0);
            tick();
            checks++;
            if (grant_id !== exp || mem_read_enable !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL rr_grant%0d got gid=%b re=%b busy=%b want gid=%b re=1 busy=1",
                                   i, grant_id, mem_read_enable, busy, exp);
            end
            checks++;
            if (mem_address !== (exp ? 32'h20 : 32'h10)) begin
                errors++; $display("FAIL rr_addr%0d got %h want %h", i, mem_address, exp ? 32'h20 : 32'h10);
            end
            mem_valid = 1; mem_read_value = 32'hA000_0000 + i;
            tick();
            checks++;
            if ({r1_done, r0_done} !== (exp ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_done%0d got %b want %b", i, {r1_done, r0_done}, exp ? 2'b10 : 2'b01);
            end
            checks++;
            if ((exp ? r1_read_value : r0_read_value) !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL rr_rdata%0d got %h want %h", i,
                                   exp ? r1_read_value : r0_read_value, 32'hA000_0000 + i);
            end
            mem_valid = 0;
            tick();
        end
        r0_read = 0; r1_read = 0;
        tick();
    endtask

    // Port 0 read at 0x100, mem_valid in cycle 3, request dropped mid-transaction.
    task automatic test_single_read;
        r0_read = 1; r0_address = 32'h100;
        tick();
        checks++;
        if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_address !== 32'h100 || grant_id !== 1'b0) begin
            errors++; $display("FAIL rd_strobe got re=%b we=%b addr=%h gid=%b want 1 0 00000100 0",
                               mem_read_enable, mem_write_enable, mem_address, grant_id);
        end
        r0_read = 0;
        tick();
        checks++;
        if (r0_done !== 1'b0 || busy !== 1'b1 || mem_read_enable !== 1'b1) begin
            errors++; $display("FAIL rd_wait got done=%b busy=%b re=%b want 0 1 1", r0_done, busy, mem_read_enable);
        end
        mem_valid = 1; mem_read_value = 32'hDEAD_BEEF;
        tick();
        mem_valid = 0;
        checks++;
        if (r0_done !== 1'b1 || r0_read_value !== 32'hDEAD_BEEF || r1_done !== 1'b0 || mem_read_enable !== 1'b0) begin
            errors++; $display("FAIL rd_done got done=%b data=%h r1_done=%b re=%b want 1 deadbeef 0 0",
                               r0_done, r0_read_value, r1_done, mem_read_enable);
        end
        checks++;
        if (r1_read_value !== 32'hA000_0002) begin
            errors++; $display("FAIL rd_other_hold got %h want a0000002", r1_read_value);
        end
        tick();
        checks++;
        if (r0_done !== 1'b0 || busy !== 1'b0 || r0_read_value !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_after got done=%b busy=%b data=%h want 0 0 deadbeef",
                               r0_done, busy, r0_read_value);
        end
    endtask

    // Port 1 with read and write both set: must be a write.
    task automatic test_write_priority;
        r1_read = 1; r1_write = 1; r1_address = 32'h40; r1_write_value = 32'h1234_5678;
        tick();
        checks++;
        if ({mem_write_enable, mem_read_enable} !== 2'b10 || mem_write_value !== 32'h1234_5678 ||
            mem_address !== 32'h40 || grant_id !== 1'b1) begin
            errors++; $display("FAIL wr_strobe got we/re=%b wdata=%h addr=%h gid=%b want 10 12345678 00000040 1",
                               {mem_write_enable, mem_read_enable}, mem_write_value, mem_address, grant_id);
        end
        r1_read = 0; r1_write = 0;
        mem_valid = 1; mem_read_value = 32'hFFFF_FFFF;
        tick();
        mem_valid = 0;
        checks++;
        if ({r1_done, r0_done} !== 2'b10 || r1_read_value !== 32'hA000_0002) begin
            errors++; $display("FAIL wr_done got done=%b rdata=%h want 10 a0000002",
                               {r1_done, r0_done}, r1_read_value);
        end
        tick();
    endtask

    // No mem_valid: error after TMO wait cycles, i.e. TMO+1 cycles after the request cycle.
    task automatic test_timeout;
        int  n;
        bit  seen_done;
        bit  seen_err;
        n = 0; seen_done = 0; seen_err = 0;
        r0_read = 1; r0_address = 32'h80;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 0) r0_read = 0;
            n++;
            if (r0_done || r1_done || r1_error) seen_done = 1;
            if (r0_error) begin
                seen_err = 1;
                break;
            end
        end
        checks++;
        if (!seen_err || n != TMO + 1) begin
            errors++; $display("FAIL tmo_distance got seen=%0d cycles=%0d want 1 %0d", seen_err, n, TMO + 1);
        end
        checks++;
        if (seen_done || busy !== 1'b0 || mem_read_enable !== 1'b0) begin
            errors++; $display("FAIL tmo_state got stray=%0d busy=%b re=%b want 0 0 0", seen_done, busy, mem_read_enable);
        end
        tick();
        checks++;
        if (r0_error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_pulse got err=%b busy=%b want 0 0", r0_error, busy);
        end
        r0_read = 1; r0_address = 32'h200;
        tick();
        r0_read = 0;
        mem_valid = 1; mem_read_value = 32'h55;
        tick();
        mem_valid = 0;
        checks++;
        if (r0_done !== 1'b1 || r0_read_value !== 32'h55) begin
            errors++; $display("FAIL tmo_recover got done=%b data=%h want 1 00000055", r0_done, r0_read_value);
        end
        tick();
    endtask

    task automatic test_stray_valid;
        mem_valid = 1; mem_read_value = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || r0_done !== 1'b0 || r1_done !== 1'b0 || r0_read_value !== 32'h55) begin
                errors++; $display("FAIL stray%0d got busy=%b d0=%b d1=%b rdata=%h want 0 0 0 00000055",
                                   i, busy, r0_done, r1_done, r0_read_value);
            end
        end
        mem_valid = 0;
    endtask

    task automatic test_reset_mid;
        r0_write = 1; r0_address = 32'h300; r0_write_value = 32'hCAFE;
        tick();
        checks++;
        if (mem_write_enable !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre got we=%b busy=%b want 1 1", mem_write_enable, busy);
        end
        reset_n = 0; r0_write = 0;
        tick();
        checks++;
        if (ctl_bits() !== 8'h00 ||
            {mem_address, mem_write_value, r0_read_value, r1_read_value} !== 128'd0) begin
            errors++; $display("FAIL rst_mid got ctl=%b addr=%h wdata=%h rd0=%h rd1=%h want zeros",
                               ctl_bits(), mem_address, mem_write_value, r0_read_value, r1_read_value);
        end
        reset_n = 1;
        r0_read = 1; r0_address = 32'h10;
        r1_read = 1; r1_address = 32'h20;
        tick();
        checks++;
        if (grant_id !== 1'b1 || mem_address !== 32'h20) begin
            errors++; $display("FAIL rst_rr got gid=%b addr=%h want 1 00000020", grant_id, mem_address);
        end
        r0_read = 0; r1_read = 0;
        mem_valid = 1; mem_read_value = 32'h99;
        tick();
        mem_valid = 0;
        checks++;
        if ({r1_done, r0_done} !== 2'b10 || {r1_error, r0_error} !== 2'b00) begin
            errors++; $display("FAIL rst_done got done=%b err=%b want 10 00", {r1_done, r0_done}, {r1_error, r0_error});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_priority();
        test_timeout();
        test_stray_valid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-low reset, reset_n, sampled only on the rising edge of clk.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of mem_valid wait cycles per transaction.
REQ-003 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock
 reset_n  in  1  synchronous active-low reset
 rN_read  in  1  read request, N = 0,1
 rN_write  in  1  write request
 rN_address  in  32  byte address, stable while request held
 rN_write_value  in  32  write data
 rN_read_value  out  32  read data, valid when rN_done is 1
 rN_done  out  1  one-cycle completion pulse
 rN_error  out  1  one-cycle timeout pulse
 mem_read_enable  out  1  memory read strobe
 mem_write_enable  out  1  memory write strobe
 mem_address  out  32  memory address
 mem_write_value  out  32  memory write data
 mem_read_value  in  32  memory read data
 mem_valid  in  1  memory completion
 busy  out  1  transaction in flight
 grant_id  out  1  requester owning the memory port

Function
REQ-004 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-005 In IDLE with no request, the FSM SHALL stay in IDLE and hold all strobes at 0.
REQ-006 In IDLE with a request, the FSM SHALL register grant_id, address, data and operation, then enter BUSY on the next edge.
REQ-007 Arbitration SHALL be round-robin: when both ports request, the port that was not granted last wins; after reset, port 0 is treated as last granted, so port 1 wins the first contention.
REQ-008 When rN_read and rN_write are both 1 on the granted port, the arbiter SHALL perform a write.
REQ-009 In BUSY, exactly one of mem_read_enable and mem_write_enable SHALL be 1.
REQ-010 In BUSY, mem_address and mem_write_value SHALL hold the latched values.
REQ-011 mem_valid SHALL be ignored outside BUSY.
REQ-012 In BUSY, when mem_valid is 1, the FSM SHALL drop the strobes, latch mem_read_value (reads only) and enter RESP.
REQ-013 In RESP, the FSM SHALL pulse rN_done of the granted port for exactly one cycle with rN_read_value valid, then return to IDLE.
REQ-014 A new grant SHALL NOT occur in RESP, so there is at least one idle cycle between back-to-back transactions.
REQ-015 Minimum latency SHALL be: request in cycle t, strobe in t+1, mem_valid in t+1, done in t+2.
REQ-016 A requester deasserting its request mid-transaction SHALL be ignored; the transaction completes and done still pulses.
REQ-017 An 8-bit wait counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_valid.
REQ-018 When the wait counter reaches TIMEOUT, the FSM SHALL drop the strobes, pulse rN_error (not rN_done) for one cycle and return to IDLE.
REQ-019 rN_read_value SHALL hold its last value when not done.
REQ-020 busy SHALL be 1 in BUSY and RESP, and 0 in IDLE.
REQ-021 The non-granted port's done and error outputs SHALL remain 0.

Reset
REQ-022 On reset, the FSM SHALL enter IDLE, and all strobes, done, error, busy, grant_id, read values, mem_address, mem_write_value and the wait counter SHALL be set to 0.
REQ-023 Reset asserted in any state, including mid-transaction, SHALL abort the transaction with no done or error pulse, and the round-robin pointer SHALL reset to port 0 as last granted.

Structure
REQ-024 The FSM state encoding and the default TIMEOUT constant SHALL reside in a shared package, mem_pkg.
REQ-025 The round-robin selection SHALL be one sub-module, rr_arbiter2: inputs req[1:0] and last grant; output grant index and grant valid.

Verification
REQ-026 Single read, port 0: addr 0x100, mem_valid in cycle 3 with data 0xDEADBEEF -> r0_done for one cycle with r0_read_value 0xDEADBEEF, and r1_done stays 0.
REQ-027 Simultaneous requests from reset, both held -> grant order 1, 0, 1, 0 across four transactions.
REQ-028 Port 1 read plus write, addr 0x40, data 0x12345678 -> only mem_write_enable, mem_write_value 0x12345678, r1_done pulses.
REQ-029 mem_valid never asserted -> r0_error pulses TIMEOUT+1 cycles after grant, then FSM returns to IDLE and accepts the next request.
REQ-030 reset_n low during BUSY -> next cycle all outputs 0, no done, and a post-reset contention is granted to port 1.
REQ-031 Stray mem_valid in IDLE -> no done, no state change.
